// File: rtl/dco_cal_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module      : dco_cal_ctrl_pkg
// Description : Shared definitions for the DCO calibration/lock sequencer:
//               state encoding, reset code and default gain/count constants.
// Revision    : 1.0 - initial release
//============================================================================
package dco_cal_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_ADJUST  = 3'd3,
        ST_TRACK   = 3'd4
    } cal_state_t;

    // Mid-scale code: the first trial of the binary search.
    localparam logic [4:0] c_THRESH_RESET = 5'd16;
    localparam logic [2:0] c_BIT_IDX_MSB  = 3'd4;

    localparam int         c_N_WIN_DEF      = 4;
    localparam int         c_SETTLE_DEF     = 2;
    localparam int         c_LOCK_CNT_DEF   = 16;
    localparam int         c_UNLOCK_CNT_DEF = 4;
    localparam int         c_CNT_W_DEF      = 8;
    localparam logic [4:0] c_KDCO_TRACK_DEF = 5'd4;
    localparam logic [4:0] c_DCO_OFFSET_DEF = 5'd0;

    function automatic logic is_busy_state(input cal_state_t s);
        return (s == ST_SETTLE) || (s == ST_MEASURE) || (s == ST_ADJUST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dco_edge_counter.sv
`default_nettype none
//============================================================================
// Module      : dco_edge_counter
// Description : Rising-edge detector on dco_clk (sampled on clk) feeding a
//               saturating counter with synchronous clear.
//   clk, reset : system clock, synchronous active-high reset
//   dco_clk    : DCO output sampled on clk
//   clear      : zero the count (wins over enable)
//   enable     : count rising edges while high
//   count      : edges counted, saturates at all-ones
// Revision    : 1.0 - initial release
//============================================================================
module dco_edge_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dco_clk,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    logic             r_dco_q;
    logic [CNT_W-1:0] r_count;
    logic             w_rise;

    assign w_rise = dco_clk & ~r_dco_q;
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dco_q <= 1'b0;
            r_count <= '0;
        end else begin
            r_dco_q <= dco_clk;
            if (clear) begin
                r_count <= '0;
            end else if (enable && w_rise && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dco_cal_ctrl.sv
`default_nettype none
//============================================================================
// Module      : dco_cal_ctrl
// Description : Calibration and lock sequencer for the 5-bit DCO. Binary
//               searches thresh_val against a reference-tick window with the
//               loop open, verifies the final code, then closes the loop and
//               reports lock from the loop-filter control word.
//   clk, reset          : system clock, synchronous active-high reset
//   start, stop         : control pulses (stop has priority)
//   ref_tick            : one-cycle pulse per reference period
//   dco_clk             : DCO output, sampled on clk
//   ctrl_sign, ctrl     : loop-filter output, sign-magnitude
//   target_cnt, cal_tol : expected edges per window, verify tolerance
//   lock_tol            : allowed |ctrl| for lock
//   thresh_val, kdco, dco_offset, loop_en : DCO / filter configuration
//   busy, cal_done, cal_fail, locked      : status
// Revision    : 1.0 - initial release
//============================================================================
module dco_cal_ctrl
    import dco_cal_ctrl_pkg::*;
#(
    parameter int         N_WIN      = c_N_WIN_DEF,
    parameter int         SETTLE     = c_SETTLE_DEF,
    parameter int         LOCK_CNT   = c_LOCK_CNT_DEF,
    parameter int         UNLOCK_CNT = c_UNLOCK_CNT_DEF,
    parameter logic [4:0] KDCO_TRACK = c_KDCO_TRACK_DEF,
    parameter logic [4:0] DCO_OFFSET = c_DCO_OFFSET_DEF,
    parameter int         CNT_W      = c_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             ref_tick,
    input  logic             dco_clk,
    input  logic             ctrl_sign,
    input  logic [4:0]       ctrl,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic [CNT_W-1:0] cal_tol,
    input  logic [4:0]       lock_tol,
    output logic [4:0]       thresh_val,
    output logic [4:0]       kdco,
    output logic [4:0]       dco_offset,
    output logic             loop_en,
    output logic             busy,
    output logic             cal_done,
    output logic             cal_fail,
    output logic             locked
);

    localparam int c_TICK_MAX = (N_WIN > SETTLE) ? N_WIN : SETTLE;
    localparam int c_TICK_W   = $clog2(c_TICK_MAX + 1);
    localparam int c_IN_W     = $clog2(LOCK_CNT + 1);
    localparam int c_OUT_W    = $clog2(UNLOCK_CNT + 1);

    cal_state_t          r_state, w_state_nxt;
    logic [4:0]          r_thresh, w_thresh_nxt, w_code;
    logic [2:0]          r_bit_idx, w_bit_idx_nxt;
    logic                r_verify, w_verify_nxt;
    logic                r_cal_fail, w_cal_fail_nxt;
    logic                r_cal_done, w_cal_done_nxt;
    logic                r_locked, w_locked_nxt;
    logic [c_TICK_W-1:0] r_tick_cnt, w_tick_cnt_nxt;
    logic [c_IN_W-1:0]   r_in_cnt, w_in_cnt_nxt;
    logic [c_OUT_W-1:0]  r_out_cnt, w_out_cnt_nxt;
    logic                r_loop_en;
    logic [4:0]          r_kdco;
    logic                r_busy;
    logic                w_edge_clear;
    logic [CNT_W-1:0]    w_edge_cnt;
    logic [CNT_W:0]      w_diff;
    logic                w_unused_sign;

    // Lock qualification uses magnitude only.
    assign w_unused_sign = ctrl_sign;

    dco_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk     (clk),
        .reset   (reset),
        .dco_clk (dco_clk),
        .clear   (w_edge_clear),
        .enable  (r_state == ST_MEASURE),
        .count   (w_edge_cnt)
    );

    // |edge_cnt - target_cnt| without wrap, one bit wider than the counter.
    assign w_diff = (w_edge_cnt >= target_cnt)
                  ? ({1'b0, w_edge_cnt} - {1'b0, target_cnt})
                  : ({1'b0, target_cnt} - {1'b0, w_edge_cnt});

    always_comb begin
        w_state_nxt    = r_state;
        w_thresh_nxt   = r_thresh;
        w_bit_idx_nxt  = r_bit_idx;
        w_verify_nxt   = r_verify;
        w_cal_fail_nxt = r_cal_fail;
        w_cal_done_nxt = 1'b0;
        w_locked_nxt   = r_locked;
        w_tick_cnt_nxt = r_tick_cnt;
        w_in_cnt_nxt   = r_in_cnt;
        w_out_cnt_nxt  = r_out_cnt;
        w_edge_clear   = 1'b0;
        w_code         = r_thresh;

        if (stop) begin
            w_state_nxt    = ST_IDLE;
            w_cal_fail_nxt = 1'b0;
            w_locked_nxt   = 1'b0;
            w_tick_cnt_nxt = '0;
            w_in_cnt_nxt   = '0;
            w_out_cnt_nxt  = '0;
        end else if (start && ((r_state == ST_IDLE) || (r_state == ST_TRACK))) begin
            w_state_nxt    = ST_SETTLE;
            w_thresh_nxt   = c_THRESH_RESET;
            w_bit_idx_nxt  = c_BIT_IDX_MSB;
            w_verify_nxt   = 1'b0;
            w_cal_fail_nxt = 1'b0;
            w_locked_nxt   = 1'b0;
            w_tick_cnt_nxt = '0;
            w_in_cnt_nxt   = '0;
            w_out_cnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (ref_tick) begin
                        if (r_tick_cnt == c_TICK_W'(SETTLE - 1)) begin
                            w_tick_cnt_nxt = '0;
                            w_edge_clear   = 1'b1;
                            w_state_nxt    = ST_MEASURE;
                        end else begin
                            w_tick_cnt_nxt = r_tick_cnt + c_TICK_W'(1);
                        end
                    end
                end
                ST_MEASURE: begin
                    // The closing tick's own cycle is still counted because
                    // the counter is enabled by the registered state.
                    if (ref_tick) begin
                        if (r_tick_cnt == c_TICK_W'(N_WIN - 1)) begin
                            w_tick_cnt_nxt = '0;
                            w_state_nxt    = ST_ADJUST;
                        end else begin
                            w_tick_cnt_nxt = r_tick_cnt + c_TICK_W'(1);
                        end
                    end
                end
                ST_ADJUST: begin
                    if (!r_verify) begin
                        // Too few edges means the DCO is too slow: drop the
                        // trial bit to speed it up.
                        if (w_edge_cnt < target_cnt) begin
                            w_code[r_bit_idx] = 1'b0;
                        end
                        if (r_bit_idx != 3'd0) begin
                            w_code[r_bit_idx - 3'd1] = 1'b1;
                            w_bit_idx_nxt            = r_bit_idx - 3'd1;
                        end else begin
                            w_verify_nxt = 1'b1;
                        end
                        w_thresh_nxt = w_code;
                        w_state_nxt  = ST_SETTLE;
                    end else begin
                        if (w_diff > {1'b0, cal_tol}) begin
                            w_cal_fail_nxt = 1'b1;
                        end
                        w_cal_done_nxt = 1'b1;
                        w_state_nxt    = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (ref_tick) begin
                        if (ctrl <= lock_tol) begin
                            if (r_in_cnt != c_IN_W'(LOCK_CNT)) begin
                                w_in_cnt_nxt = r_in_cnt + c_IN_W'(1);
                            end
                            w_out_cnt_nxt = '0;
                            if (r_in_cnt >= c_IN_W'(LOCK_CNT - 1)) begin
                                w_locked_nxt = 1'b1;
                            end
                        end else begin
                            if (r_out_cnt != c_OUT_W'(UNLOCK_CNT)) begin
                                w_out_cnt_nxt = r_out_cnt + c_OUT_W'(1);
                            end
                            w_in_cnt_nxt = '0;
                            if (r_out_cnt >= c_OUT_W'(UNLOCK_CNT - 1)) begin
                                w_locked_nxt = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_thresh   <= c_THRESH_RESET;
            r_bit_idx  <= c_BIT_IDX_MSB;
            r_verify   <= 1'b0;
            r_cal_fail <= 1'b0;
            r_cal_done <= 1'b0;
            r_locked   <= 1'b0;
            r_tick_cnt <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_loop_en  <= 1'b0;
            r_kdco     <= 5'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_thresh   <= w_thresh_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_verify   <= w_verify_nxt;
            r_cal_fail <= w_cal_fail_nxt;
            r_cal_done <= w_cal_done_nxt;
            r_locked   <= w_locked_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_in_cnt   <= w_in_cnt_nxt;
            r_out_cnt  <= w_out_cnt_nxt;
            // Configuration outputs are registered from the next state so
            // they switch on the same edge as the state itself.
            r_loop_en  <= (w_state_nxt == ST_TRACK);
            r_kdco     <= (w_state_nxt == ST_TRACK) ? KDCO_TRACK : 5'd0;
            r_busy     <= is_busy_state(w_state_nxt);
        end
    end

    assign thresh_val = r_thresh;
    assign kdco       = r_kdco;
    assign dco_offset = DCO_OFFSET;
    assign loop_en    = r_loop_en;
    assign busy       = r_busy;
    assign cal_done   = r_cal_done;
    assign cal_fail   = r_cal_fail;
    assign locked     = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_dco_cal_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_dco_cal_ctrl
// Description : Self-checking bench for dco_cal_ctrl. A DCO model whose
//               half-period is (thresh_val+1) clk cycles supplies dco_clk;
//               expected codes come from a scan for the slowest code that
//               still meets the target edge count.
// Revision    : 1.0 - initial release
//============================================================================
module tb_dco_cal_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop;
    logic       ref_tick = 1'b0;
    logic       dco_clk  = 1'b0;
    logic       ctrl_sign;
    logic [4:0] ctrl, lock_tol;
    logic [7:0] target_cnt, cal_tol;
    logic [4:0] thresh_val, kdco, dco_offset;
    logic       loop_en, busy, cal_done, cal_fail, locked;

    int n_tests = 0;
    int n_fail  = 0;
    int ref_p     = 64;
    int ref_phase = 0;
    int dco_mode  = 0;   // 0: code-controlled DCO, 1: toggle every cycle
    int dco_acc   = 0;
    int done_seen = 0;
    int run_in, run_out;
    bit m_locked;

    always #5 clk = ~clk;

    dco_cal_ctrl u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .ref_tick   (ref_tick),
        .dco_clk    (dco_clk),
        .ctrl_sign  (ctrl_sign),
        .ctrl       (ctrl),
        .target_cnt (target_cnt),
        .cal_tol    (cal_tol),
        .lock_tol   (lock_tol),
        .thresh_val (thresh_val),
        .kdco       (kdco),
        .dco_offset (dco_offset),
        .loop_en    (loop_en),
        .busy       (busy),
        .cal_done   (cal_done),
        .cal_fail   (cal_fail),
        .locked     (locked)
    );

    // Reference tick and DCO waveform, updated away from the active edge.
    always @(negedge clk) begin
        ref_phase = (ref_phase + 1 >= ref_p) ? 0 : ref_phase + 1;
        ref_tick  = (ref_phase == 0);
        if (dco_mode == 1) begin
            dco_clk = ~dco_clk;
        end else begin
            dco_acc++;
            if (dco_acc >= int'(thresh_val) + 1) begin
                dco_clk = ~dco_clk;
                dco_acc = 0;
            end
        end
    end

    always @(negedge clk) if (cal_done === 1'b1) done_seen++;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Edges in one window of 4 reference periods for a steady code; a
    // window not aligned to the DCO period sees either floor or ceil.
    function automatic int cnt_at(input int code, input bit hi);
        int w, p, c;
        w = 4 * ref_p;
        if (dco_mode == 1) begin
            c = w / 2;
        end else begin
            p = 2 * (code + 1);
            c = hi ? (w + p - 1) / p : w / p;
        end
        return (c > 255) ? 255 : c;
    endfunction

    function automatic bit ambiguous(input int tgt);
        for (int c = 0; c < 32; c++)
            if ((cnt_at(c, 0) >= tgt) != (cnt_at(c, 1) >= tgt)) return 1'b1;
        return 1'b0;
    endfunction

    // Slowest (largest) code whose edge count still reaches the target.
    function automatic int ref_code(input int tgt);
        for (int c = 31; c >= 0; c--)
            if (cnt_at(c, 0) >= tgt) return c;
        return 0;
    endfunction

    function automatic bit ref_fail(input int code, input int tgt, input int tol, input bit hi);
        int d;
        d = cnt_at(code, hi) - tgt;
        if (d < 0) d = -d;
        return d > tol;
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_thresh"},   thresh_val, 16);
        check_eq({tag, "_kdco"},     kdco,       0);
        check_eq({tag, "_offset"},   dco_offset, 0);
        check_eq({tag, "_loop_en"},  loop_en,    0);
        check_eq({tag, "_busy"},     busy,       0);
        check_eq({tag, "_cal_done"}, cal_done,   0);
        check_eq({tag, "_cal_fail"}, cal_fail,   0);
        check_eq({tag, "_locked"},   locked,     0);
    endtask

    task automatic run_cal(input int tgt, input int tol, input bit inject, input string tag);
        int exp_code, guard;
        bit exp_fail;
        exp_code = ref_code(tgt);
        exp_fail = ref_fail(exp_code, tgt, tol, 1'b0);
        @(negedge clk);
        target_cnt = 8'(tgt);
        cal_tol    = 8'(tol);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy_start"}, busy,     1);
        check_eq({tag, "_fail_clr"},   cal_fail, 0);
        check_eq({tag, "_lock_clr"},   locked,   0);
        done_seen = 0;
        guard     = 0;
        while (cal_done !== 1'b1 && guard < 40 * ref_p + 100) begin
            @(negedge clk);
            guard++;
            start = inject && (guard == 9 * ref_p);
        end
        start = 1'b0;
        check_eq({tag, "_done"},     cal_done,   1);
        check_eq({tag, "_code"},     thresh_val, exp_code);
        check_eq({tag, "_cal_fail"}, cal_fail,   exp_fail);
        check_eq({tag, "_loop_en"},  loop_en,    1);
        check_eq({tag, "_kdco"},     kdco,       4);
        check_eq({tag, "_busy_end"}, busy,       0);
        repeat (10) @(negedge clk);
        check_eq({tag, "_pulses"}, done_seen, 1);
    endtask

    task automatic wait_ticks(input int n);
        int seen, guard;
        seen  = 0;
        guard = 0;
        while (seen < n && guard < (n + 1) * ref_p + 10) begin
            @(posedge clk);
            guard++;
            if (ref_tick) seen++;
        end
        #1;
        if (seen < n) check_eq("tick_wait", seen, n);
    endtask

    // One reference period with ctrl held; lock follows the run lengths of
    // in/out-of-tolerance ticks.
    task automatic lock_step(input int c, input int tol, input string tag);
        @(negedge clk);
        ctrl      = 5'(c);
        ctrl_sign = ($urandom_range(0, 1) != 0);
        lock_tol  = 5'(tol);
        wait_ticks(1);
        if (c <= tol) begin
            run_in++;
            run_out = 0;
            if (run_in >= 16) m_locked = 1'b1;
        end else begin
            run_out++;
            run_in = 0;
            if (run_out >= 4) m_locked = 1'b0;
        end
        check_eq(tag, locked, m_locked);
    endtask

    initial begin
        int tgt, tol, tries, c;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        ctrl = 5'd31; ctrl_sign = 1'b0; lock_tol = 5'd3;
        target_cnt = 8'd16; cal_tol = 8'd2;
        repeat (3) @(negedge clk);
        check_reset("rst");
        reset = 1'b0;

        run_cal(16, 2, 1'b0, "basic");
        check_eq("basic_code7", thresh_val, 7);

        run_in = 0; run_out = 0; m_locked = 1'b0;
        for (int i = 0; i < 16; i++) lock_step(2, 3, "lock_in");
        for (int i = 0; i < 4; i++)  lock_step(10, 3, "lock_out");
        for (int i = 0; i < 16; i++) lock_step(1, 3, "relock");
        check_eq("relock_hi", locked, 1);

        // Restart from TRACK while locked; target cannot be reached.
        run_cal(200, 2, 1'b0, "unreach");
        check_eq("unreach_code0", thresh_val, 0);
        check_eq("unreach_fail",  cal_fail,   1);

        run_in = 0; run_out = 0; m_locked = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tol = $urandom_range(2, 12);
            c   = ($urandom_range(0, 4) != 0) ? $urandom_range(0, tol) : $urandom_range(tol + 1, 31);
            lock_step(c, tol, "lock_rand");
        end

        for (int k = 0; k < 4; k++) begin
            tries = 0;
            tgt   = $urandom_range(2, 150);
            while (ambiguous(tgt) && tries < 200) begin
                tgt = $urandom_range(2, 150);
                tries++;
            end
            tries = 0;
            tol   = $urandom_range(0, 8);
            while ((ref_fail(ref_code(tgt), tgt, tol, 1'b0) != ref_fail(ref_code(tgt), tgt, tol, 1'b1))
                   && tries < 50) begin
                tol = $urandom_range(0, 8);
                tries++;
            end
            run_cal(tgt, tol, (k % 2) == 1, "rand_cal");
        end

        // stop during MEASURE (from TRACK)
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_ticks(3);
        check_eq("meas_busy", busy, 1);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        check_eq("stop_busy",    busy,       0);
        check_eq("stop_loop_en", loop_en,    0);
        check_eq("stop_kdco",    kdco,       0);
        check_eq("stop_thresh",  thresh_val, 16);

        // reset during SETTLE of the second search step
        @(negedge clk); target_cnt = 8'd16; cal_tol = 8'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_ticks(7);
        @(negedge clk);
        check_eq("step2_thresh", thresh_val, (cnt_at(16, 0) >= 16) ? 24 : 8);
        check_eq("step2_busy",   busy,       1);
        reset = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        reset = 1'b0;

        // start and stop together from IDLE
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check_eq("ss_idle_busy", busy, 0);

        // edge counter saturation: 1024-cycle window, edge every 2 cycles
        ref_p    = 256;
        dco_mode = 1;
        run_cal(255, 0, 1'b0, "sat");
        check_eq("sat_code31", thresh_val, 31);

        // start and stop together from TRACK
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check_eq("ss_track_busy",    busy,    0);
        check_eq("ss_track_loop_en", loop_en, 0);
        check_eq("ss_track_kdco",    kdco,    0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
